// File: rtl/slave_write_pkg.sv
// Shared encodings for the AXI write responder: response codes, burst types,
// the one legal beat size and the write FSM state type.
package slave_write_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // WRAP bursts only make sense for power-of-two beat counts (2, 4, 8, 16).
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/slave_write_if.sv
// AXI write-side channels (AW, W, B) between the interconnect and one slave.
interface slave_write_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

endinterface

// File: rtl/slave_write_addr_gen.sv
// Next word pointer for an AXI burst (FIXED / INCR / WRAP). Purely
// combinational so the read responder can reuse it unchanged.
module axi_burst_addr_gen
    import slave_write_pkg::*;
#(
    parameter int PTR_W = 14,
    parameter int LEN_W = 4
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       burst,
    output logic [PTR_W-1:0] next_ptr
);

    logic [PTR_W-1:0] wrap_mask;
    logic [PTR_W-1:0] ptr_inc;

    // For a legal WRAP length, len itself is the mask of the low pointer bits
    // that move inside the aligned window; the upper bits stay put.
    always_comb begin
        wrap_mask             = '0;
        wrap_mask[LEN_W-1:0]  = len;
        ptr_inc               = ptr + PTR_W'(1);
        next_ptr              = ptr;
        case (burst)
            BURST_INCR: next_ptr = ptr_inc;
            BURST_WRAP: next_ptr = (ptr & ~wrap_mask) | (ptr_inc & wrap_mask);
            default:    next_ptr = ptr;
        endcase
    end

endmodule

// File: rtl/slave_write.sv
// AXI write responder for one SRAM-backed slave: takes one AW, absorbs the
// burst on W, issues one registered byte-masked SRAM write per beat, and
// returns a single B response.
module slave_write
    import slave_write_pkg::*;
#(
    parameter int ID_W     = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 4,
    parameter int SRAM_A_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            slave_id,
    slave_write_if.slave          bus,
    output logic                  CS,
    output logic [DATA_W/8-1:0]   WEB,
    output logic [SRAM_A_W-1:0]   A,
    output logic [DATA_W-1:0]     DI
);

    state_t              state;
    state_t              state_d;
    logic [ID_W-1:0]     id_q;
    logic [SRAM_A_W-1:0] ptr_q;
    logic [SRAM_A_W-1:0] ptr_next;
    logic [LEN_W-1:0]    len_q;
    logic [1:0]          burst_q;
    logic [LEN_W-1:0]    count_q;
    logic                dec_err;
    logic                size_err;
    logic                proto_err;
    logic                aw_rdy;
    logic                w_rdy;
    logic                b_vld;
    logic                last_beat;
    logic [1:0]          resp;

    assign last_beat = (count_q == len_q);

    axi_burst_addr_gen #(
        .PTR_W (SRAM_A_W),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .ptr      (ptr_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_ptr (ptr_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state and channel handshakes; an unreachable encoding falls back to IDLE.
    always_comb begin
        state_d = state;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        b_vld   = 1'b0;
        case (state)
            S_IDLE: begin
                aw_rdy = 1'b1;
                if (bus.AWVALID) state_d = S_DATA;
            end
            S_DATA: begin
                w_rdy = 1'b1;
                if (bus.WVALID && last_beat) state_d = S_RESP;
            end
            S_RESP: begin
                b_vld = 1'b1;
                if (bus.BREADY) state_d = S_RESP == state ? S_IDLE : state;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // DECERR outranks SLVERR; both come from flags frozen during the burst.
    always_comb begin
        resp = RESP_OKAY;
        if (dec_err)                    resp = RESP_DECERR;
        else if (size_err || proto_err) resp = RESP_SLVERR;
    end

    // AWREADY is masked while reset is held so it reads low during reset.
    assign bus.AWREADY = aw_rdy & ~rst;
    assign bus.WREADY  = w_rdy;
    assign bus.BVALID  = b_vld;
    assign bus.BID     = b_vld ? id_q : '0;
    assign bus.BRESP   = b_vld ? resp : RESP_OKAY;

    // Burst context capture, beat counting and the one-cycle SRAM write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            burst_q   <= BURST_FIXED;
            count_q   <= '0;
            dec_err   <= 1'b0;
            size_err  <= 1'b0;
            proto_err <= 1'b0;
            CS        <= 1'b0;
            WEB       <= '1;
            A         <= '0;
            DI        <= '0;
        end else begin
            CS  <= 1'b0;
            WEB <= '1;
            case (state)
                S_IDLE: begin
                    if (bus.AWVALID) begin
                        id_q      <= bus.AWID;
                        ptr_q     <= bus.AWADDR[SRAM_A_W+1:2];
                        len_q     <= bus.AWLEN;
                        burst_q   <= bus.AWBURST;
                        count_q   <= '0;
                        dec_err   <= (bus.AWADDR[31:16] != {8'h00, slave_id});
                        size_err  <= (bus.AWSIZE != SIZE_WORD) ||
                                     ((bus.AWBURST == BURST_WRAP) && !wrap_len_ok(bus.AWLEN));
                        proto_err <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bus.WVALID) begin
                        if (!dec_err && !size_err) begin
                            CS  <= 1'b1;
                            A   <= ptr_q;
                            DI  <= bus.WDATA;
                            WEB <= ~bus.WSTRB;
                        end
                        if (bus.WLAST != last_beat) proto_err <= 1'b1;
                        ptr_q   <= ptr_next;
                        count_q <= count_q + LEN_W'(1);
                    end
                end
                S_RESP: ;
                default: begin
                    id_q      <= '0;
                    count_q   <= '0;
                    dec_err   <= 1'b0;
                    size_err  <= 1'b0;
                    proto_err <= 1'b0;
                    A         <= '0;
                    DI        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_write.sv
// Bench for slave_write: scenario tasks push expected SRAM writes and B
// responses into queues; a negedge monitor collects the observed writes.
module tb_slave_write;

    typedef struct packed {
        logic [13:0] a;
        logic [3:0]  web;
        logic [31:0] di;
    } wr_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_t;

    logic        clk;
    logic        rst;
    logic [7:0]  slave_id;
    logic        CS;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;

    int checks;
    int errors;

    wr_t exp_q[$];
    wr_t obs_q[$];
    b_t  b_exp_q[$];

    slave_write_if bus ();

    slave_write dut (
        .clk      (clk),
        .rst      (rst),
        .slave_id (slave_id),
        .bus      (bus),
        .CS       (CS),
        .WEB      (WEB),
        .A        (A),
        .DI       (DI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every SRAM write cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (CS === 1'b1) obs_q.push_back('{a: A, web: WEB, di: DI});
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
        bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bus.AWREADY) begin errors++; $display("[TB] FAIL aw_timeout AWREADY=%b required 1", bus.AWREADY); end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        @(negedge clk);
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bus.WREADY) begin errors++; $display("[TB] FAIL w_timeout WREADY=%b required 1", bus.WREADY); end
        @(posedge clk); #1;
    endtask

    task automatic get_b(output logic [7:0] id, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bus.BVALID) begin errors++; $display("[TB] FAIL b_timeout BVALID=%b required 1", bus.BVALID); end
        id = bus.BID; resp = bus.BRESP;
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, CS, WEB, A, DI} !== {3'b000, 8'h00, 2'b00, 1'b0, 4'hF, 14'h0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_state aw=%b w=%b b=%b bid=%h bresp=%b cs=%b web=%h a=%h di=%h required all idle, web=F",
                     bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, CS, WEB, A, DI);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.AWREADY !== 1'b1) begin errors++; $display("[TB] FAIL reset_release AWREADY=%b required 1", bus.AWREADY); end
    endtask

    task automatic test_single();
        logic [7:0] id; logic [1:0] resp; b_t eb; wr_t e, o;
        // W presented while idle must not be taken
        @(negedge clk);
        bus.WVALID = 1'b1; bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'hF; bus.WLAST = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.WREADY !== 1'b0 || CS !== 1'b0) begin errors++; $display("[TB] FAIL idle_w WREADY=%b CS=%b required 0 0", bus.WREADY, CS); end
        end
        bus.WVALID = 1'b0;
        b_exp_q.push_back('{id: 8'h5A, resp: 2'b00});
        drive_aw(8'h5A, 32'h0001_0010, 4'd0, 3'b010, 2'b01);
        exp_q.push_back('{a: 14'h4, web: 4'h0, di: 32'hDEAD_BEEF});
        drive_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        bus.WVALID = 1'b0;
        @(negedge clk);
        checks++;
        if ({CS, A, WEB, DI} !== {1'b1, 14'h4, 4'h0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL single_latency cs=%b a=%h web=%h di=%h required 1 4 0 deadbeef", CS, A, WEB, DI);
        end
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL single_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL single_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL single_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_incr();
        logic [7:0] id; logic [1:0] resp; b_t eb; wr_t e, o; logic [3:0] strb;
        b_exp_q.push_back('{id: 8'h21, resp: 2'b00});
        drive_aw(8'h21, 32'h0001_0100, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            strb = (i == 2) ? 4'b0101 : 4'hF;
            exp_q.push_back('{a: 14'h40 + 14'(i), web: ~strb, di: 32'hA000_0000 + 32'(i)});
            drive_w(32'hA000_0000 + 32'(i), strb, i == 3);
        end
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL incr_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        @(negedge clk);
        checks++;
        if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL incr_single_b BVALID=%b required 0", bus.BVALID); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL incr_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL incr_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        logic [7:0] id; logic [1:0] resp; b_t eb; wr_t e, o; logic [3:0] strb;
        logic [13:0] addrs [4] = '{14'd6, 14'd7, 14'd4, 14'd5};
        b_exp_q.push_back('{id: 8'h33, resp: 2'b00});
        drive_aw(8'h33, 32'h0001_0018, 4'd3, 3'b010, 2'b10);
        for (int i = 0; i < 4; i++) begin
            strb = (i == 3) ? 4'h0 : 4'hF;
            exp_q.push_back('{a: addrs[i], web: ~strb, di: 32'hB000_0010 + 32'(i)});
            drive_w(32'hB000_0010 + 32'(i), strb, i == 3);
        end
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL wrap_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL wrap_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL wrap_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_decode_miss();
        logic [7:0] id; logic [1:0] resp; b_t eb;
        b_exp_q.push_back('{id: 8'h44, resp: 2'b11});
        drive_aw(8'h44, 32'h0002_0000, 4'd1, 3'b010, 2'b01);
        drive_w(32'h1111_1111, 4'hF, 1'b0);
        drive_w(32'h2222_2222, 4'hF, 1'b1);
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL decerr_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL decerr_nowrite got %0d writes required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_wlast_err();
        logic [7:0] id; logic [1:0] resp; b_t eb; wr_t e, o;
        b_exp_q.push_back('{id: 8'h55, resp: 2'b10});
        drive_aw(8'h55, 32'h0001_0200, 4'd1, 3'b010, 2'b01);
        exp_q.push_back('{a: 14'h80, web: 4'h0, di: 32'hC0C0_0000});
        drive_w(32'hC0C0_0000, 4'hF, 1'b1);
        exp_q.push_back('{a: 14'h81, web: 4'h0, di: 32'hC0C0_0001});
        drive_w(32'hC0C0_0001, 4'hF, 1'b1);
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL wlast_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL wlast_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL wlast_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_size_err();
        logic [7:0] id; logic [1:0] resp; b_t eb;
        b_exp_q.push_back('{id: 8'h66, resp: 2'b10});
        drive_aw(8'h66, 32'h0001_0300, 4'd1, 3'b001, 2'b01);
        drive_w(32'h3333_3333, 4'hF, 1'b0);
        drive_w(32'h4444_4444, 4'hF, 1'b1);
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL size_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL size_nowrite got %0d writes required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        int n = 0; b_t eb; wr_t e, o;
        b_exp_q.push_back('{id: 8'h77, resp: 2'b00});
        drive_aw(8'h77, 32'h0001_0040, 4'd0, 3'b010, 2'b00);
        exp_q.push_back('{a: 14'h10, web: 4'h6, di: 32'h0BAD_F00D});
        drive_w(32'h0BAD_F00D, 4'h9, 1'b1);
        bus.WVALID = 1'b0;
        @(negedge clk);
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        eb = b_exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY} !== {1'b1, eb.id, eb.resp, 1'b0}) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d bvalid=%b bid=%h bresp=%b awready=%b required 1 %h %b 0",
                         i, bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY, eb.id, eb.resp);
            end
            @(negedge clk);
        end
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.AWREADY !== 1'b1 || bus.BVALID !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_release awready=%b bvalid=%b required 1 0", bus.AWREADY, bus.BVALID);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bp_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL bp_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] id; logic [1:0] resp; b_t eb; wr_t e, o;
        drive_aw(8'h88, 32'h0001_0400, 4'd3, 3'b010, 2'b01);
        drive_w(32'h5555_0000, 4'hF, 1'b0);
        drive_w(32'h5555_0001, 4'hF, 1'b0);
        bus.WVALID = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, CS, WEB, A, DI} !== {3'b000, 8'h00, 2'b00, 1'b0, 4'hF, 14'h0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL midrst_state aw=%b w=%b b=%b bid=%h bresp=%b cs=%b web=%h a=%h di=%h required all idle, web=F",
                     bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, CS, WEB, A, DI);
        end
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1) begin
                errors++; $display("[TB] FAIL midrst_noB bvalid=%b awready=%b required 0 1", bus.BVALID, bus.AWREADY);
            end
        end
        b_exp_q.push_back('{id: 8'h99, resp: 2'b00});
        drive_aw(8'h99, 32'h0001_0020, 4'd0, 3'b010, 2'b01);
        exp_q.push_back('{a: 14'h8, web: 4'h0, di: 32'hFEED_FACE});
        drive_w(32'hFEED_FACE, 4'hF, 1'b1);
        bus.WVALID = 1'b0;
        get_b(id, resp);
        eb = b_exp_q.pop_front();
        checks++;
        if ({id, resp} !== eb) begin errors++; $display("[TB] FAIL midrst_b id=%h resp=%b required %h %b", id, resp, eb.id, eb.resp); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL midrst_wcount got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("[TB] FAIL midrst_wr a=%h web=%h di=%h required %h %h %h", o.a, o.web, o.di, e.a, e.web, e.di); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; slave_id = 8'h01;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'b010;
        bus.AWBURST = 2'b01; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_decode_miss();
        test_wlast_err();
        test_size_err();
        test_backpressure();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_write.md
Name: slave_write

Overview:
AXI write-channel responder (AW/W/B) for one SRAM-backed slave (IM or DM). It is the write-side counterpart of the slave read responder and sits between the AXI interconnect and the SRAM macro port. It accepts one address phase, absorbs a burst of data beats, drives byte-masked SRAM writes, and returns a single B response.

Parameters:
ID_W, 8, AW/B ID width (`AXI_IDS_BITS)
ADDR_W, 32, AXI address width (`AXI_ADDR_BITS)
DATA_W, 32, AXI data width (`AXI_DATA_BITS); strobe width is DATA_W/8
LEN_W, 4, AWLEN width (`AXI_LEN_BITS)
SRAM_A_W, 14, SRAM word-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
slave_id  in  8  slave decode tag; address hit when AWADDR[31:16]=={8'h00,slave_id}
AWID  in  ID_W  write address ID
AWADDR  in  ADDR_W  start byte address
AWLEN  in  LEN_W  beats minus 1
AWSIZE  in  3  beat size; only 3'b010 is legal
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WLAST  in  1  last beat flag from master
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  ID_W  response ID (captured AWID)
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
BVALID  out  1  response valid
BREADY  in  1  response ready
CS  out  1  SRAM chip select, write cycle
WEB  out  4  SRAM byte write enables, active-low
A  out  SRAM_A_W  SRAM word address
DI  out  32  SRAM write data

Behaviour:
- Reset (rst=1, async): state IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, CS=0, WEB=4'hF, A=0, DI=0; beat counter and error flags cleared. Reset mid-burst abandons the transaction; no B response is issued.
- States: IDLE -> DATA -> RESP -> IDLE. 2'b11 is illegal and recovers to IDLE with all outputs at their reset values.
- IDLE:
  - AWREADY=1, WREADY=0, BVALID=0.
  - On AWVALID&&AWREADY, capture AWID, AWADDR[SRAM_A_W+1:2] as word pointer, AWLEN, AWBURST.
  - Set dec_err = (AWADDR[31:16] != {8'h00,slave_id}) and size_err = (AWSIZE != 3'b010). Clear the beat counter and go to DATA.
  - W beats presented in IDLE are not accepted.
- DATA:
  - AWREADY=0, WREADY=1.
  - Each WVALID&&WREADY is one beat. If neither dec_err nor size_err is set, the beat is written to SRAM on the next cycle:
    - CS=1 for exactly one cycle.
    - A=pointer, DI=WDATA, WEB=~WSTRB.
    - Otherwise CS=0 and WEB=4'hF: the data is consumed and dropped.
  - Write latency: one cycle from handshake to CS pulse.
  - Set proto_err if WLAST != (count==AWLEN) on any beat.
  - Pointer update after each beat:
    - FIXED: unchanged.
    - INCR: +1, wrapping modulo 2^SRAM_A_W.
    - WRAP: increment within an aligned window of (AWLEN+1) words. Only AWLEN of 1, 3, 7 or 15 is legal; any other AWLEN with WRAP sets size_err at AW capture.
  - The burst ends on the handshake where count==AWLEN, regardless of WLAST; go to RESP.
  - WSTRB=0 still produces a CS pulse with WEB=4'hF.
- RESP:
  - BVALID=1, BID=captured AWID, WREADY=0, AWREADY=0.
  - BRESP priority: DECERR (dec_err), then SLVERR (size_err or proto_err), else OKAY.
  - BID and BRESP hold stable until BREADY. On BVALID&&BREADY go to IDLE; AWREADY rises the following cycle, so back-to-back transactions have one idle cycle.
- The final-beat SRAM write (CS pulse) coincides with the first RESP cycle, so BVALID is never asserted before the last write has been issued.

Decomposition:
- Shared package axi_pkg: BRESP encodings (OKAY/SLVERR/DECERR), burst-type encodings, the legal size constant 3'b010, and the state enum {S_IDLE, S_DATA, S_RESP}. The existing `AXI_*_BITS defines stay the width source.
- One natural sub-module: axi_burst_addr_gen. Inputs: pointer, AWLEN, AWBURST. Output: next word pointer. It is purely combinational, handles FIXED/INCR/WRAP, and can be reused by the read side.

Test Plan:
- Single INCR write: AWADDR=0x0001_0010, slave_id=1, AWLEN=0, WSTRB=4'hF, WDATA=0xDEADBEEF -> one cycle after W handshake CS=1, A=4, WEB=4'h0, DI=0xDEADBEEF; then BVALID=1, BRESP=00, BID=AWID.
- INCR burst: AWLEN=3, AWADDR=0x0001_0100, WSTRB=4'b0101 on beat 2 -> CS pulses with A=0x40..0x43; beat 2 WEB=4'b1010; exactly one B response, OKAY.
- WRAP burst: AWLEN=3, AWADDR=0x0001_0018 -> A sequence 6, 7, 4, 5; BRESP=00.
- Decode miss: AWADDR=0x0002_0000 with slave_id=1, AWLEN=1 -> two beats accepted, CS never asserted, BRESP=11.
- Protocol errors:
  - WLAST asserted on beat 0 of AWLEN=1 -> both beats still written, BRESP=10.
  - AWSIZE=3'b001 -> no writes, BRESP=10.
- Back-pressure and reset:
  - BREADY held low 5 cycles -> BVALID/BID/BRESP stable throughout, AWREADY=0 until one cycle after the handshake.
  - rst pulsed mid-burst -> all outputs at reset values immediately, then a new AW is accepted normally.
